reversed_pair_serializer: RTL

- Downstream stage of the byte bit-reversal block. Consumes its two WIDTH-bit outputs (reversed a, reversed b) and shifts them out as one serial frame.
- Upstream interface is a valid/ready handshake; downstream is a 1-bit stream with a valid strobe and first/last frame markers.
- Frame order: the whole a word first, then the whole b word, each LSB first.

---
 rtl/serializer_pkg.sv | 21 ++
 rtl/pair_shift_reg.sv | 41 ++++
 rtl/reversed_pair_serializer.sv | 108 ++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types and constants for the reversed-pair serializer.
// SERIALIZER_PARITY_EN adds a trailing even-parity bit to every frame.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int frame_len(input int width);
`ifdef SERIALIZER_PARITY_EN
    return 2 * width + 1;
`else
    return 2 * width;
`endif
  endfunction

endpackage

// File: rtl/pair_shift_reg.sv
// Parallel-load, shift-right register holding {b, a} plus the bit counter
// that marks the first and last data bit of a frame.
module pair_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             bit_out,
  output logic             first,
  output logic             last
);

  localparam int CW = $clog2(2 * WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(2 * WIDTH - 1);

  logic [2*WIDTH-1:0] shreg;
  logic [CW-1:0]      count;

  // Load takes priority so a back-to-back accept on the last edge restarts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
    end else if (load) begin
      shreg <= {b_in, a_in};
      count <= '0;
    end else if (shift) begin
      shreg <= {1'b0, shreg[2*WIDTH-1:1]};
      count <= count + CW'(1);
    end
  end

  assign bit_out = shreg[0];
  assign first   = (count == '0);
  assign last    = (count == LAST_IDX);

endmodule

// File: rtl/reversed_pair_serializer.sv
// Serializes a pair of WIDTH-bit words (a then b, LSB first) behind a valid/ready handshake.
// Optional trailing parity bit via SERIALIZER_PARITY_EN.
module reversed_pair_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  ser_state_t state, state_next;
  logic load, shift, sr_bit, sr_first, sr_last;

  pair_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .shift   (shift),
    .a_in    (a_in),
    .b_in    (b_in),
    .bit_out (sr_bit),
    .first   (sr_first),
    .last    (sr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

`ifdef SERIALIZER_PARITY_EN
  // Running XOR of the bits already sent, so the parity cycle needs no wide reduction.
  logic parity;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              parity <= 1'b0;
    else if (load)           parity <= 1'b0;
    else if (state == SHIFT) parity <= parity ^ sr_bit;
  end
`endif

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    ser_first  = 1'b0;
    ser_last   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        ser_out   = sr_bit;
        ser_valid = 1'b1;
        ser_first = sr_first;
        shift     = 1'b1;
`ifdef SERIALIZER_PARITY_EN
        if (sr_last) state_next = PARITY;
`else
        ser_last = sr_last;
        in_ready = sr_last;
        if (sr_last) begin
          if (in_valid) begin
            load       = 1'b1;
            state_next = SHIFT;
          end else begin
            state_next = IDLE;
          end
        end
`endif
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        ser_out   = parity;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        in_ready  = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
